// File: rtl/fft_stage_pipe_if.sv
// rtl/fft_stage_pipe_if.sv - pair stream in/out plus twiddle write port for fft_stage_pipe
interface fft_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int N      = 16
);
  localparam int PW = $clog2(N / 2);

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_first;
  logic [2*DATA_W-1:0]   in_a;
  logic [2*DATA_W-1:0]   in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DATA_W-1:0]   out_a;
  logic [2*DATA_W-1:0]   out_b;
  logic                  out_last;
  logic                  tw_we;
  logic [PW-1:0]         tw_addr;
  logic [2*DATA_W-1:0]   tw_data;

  modport master (
    output in_valid, in_first, in_a, in_b, out_ready, tw_we, tw_addr, tw_data,
    input  in_ready, out_valid, out_a, out_b, out_last
  );

  modport slave (
    input  in_valid, in_first, in_a, in_b, out_ready, tw_we, tw_addr, tw_data,
    output in_ready, out_valid, out_a, out_b, out_last
  );
endinterface

// File: rtl/fft_stage_pipe.sv
// rtl/fft_stage_pipe.sv - two-stage radix-2 DIF butterfly with writable twiddle table
// FFT_ROUND_EN: round half up on the twiddle product instead of truncating.
module fft_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int N      = 16,
  parameter int STAGE  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  fft_stage_pipe_if.slave s
);
  localparam int NP     = N / 2;
  localparam int PW     = $clog2(NP);
  localparam int PROD_W = 2 * DATA_W + 2;
  localparam logic [PW-1:0] SPAN_MASK = PW'((N >> (STAGE + 1)) - 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(NP - 1);
  localparam logic [2*DATA_W-1:0] UNITY = {DATA_W'(1) << FRAC_W, {DATA_W{1'b0}}};
`ifdef FFT_ROUND_EN
  localparam logic signed [PROD_W-1:0] RND = PROD_W'(1) << (FRAC_W - 1);
`else
  localparam logic signed [PROD_W-1:0] RND = '0;
`endif

  logic                       en, xfer_in;
  logic [PW-1:0]              cur, k;
  logic [PW-1:0]              pcnt_q, pcnt_d;
  logic [2*DATA_W-1:0]        tw_q [NP];
  logic [2*DATA_W-1:0]        tw_d [NP];
  logic                       s1_valid_q, s1_valid_d;
  logic [2*DATA_W-1:0]        s1_sum_q, s1_sum_d;
  logic signed [DATA_W:0]     s1_dr_q, s1_dr_d, s1_di_q, s1_di_d;
  logic [2*DATA_W-1:0]        s1_w_q, s1_w_d;
  logic                       s1_last_q, s1_last_d;
  logic                       out_valid_q, out_valid_d;
  logic [2*DATA_W-1:0]        out_a_q, out_a_d, out_b_q, out_b_d;
  logic                       out_last_q, out_last_d;
  logic signed [PROD_W-1:0]   dr_x, di_x, wr_x, wi_x, p_re, p_im;

  // One enable stalls the whole pipe; a bubble in S2 never blocks input.
  assign en          = !out_valid_q || s.out_ready;
  assign xfer_in     = s.in_valid && en;
  assign s.in_ready  = en;
  assign s.out_valid = out_valid_q;
  assign s.out_a     = out_a_q;
  assign s.out_b     = out_b_q;
  assign s.out_last  = out_last_q;

  always_comb begin
    cur = s.in_first ? '0 : pcnt_q;
    k   = (cur & SPAN_MASK) << STAGE;

    pcnt_d = pcnt_q;
    if (xfer_in) pcnt_d = cur + 1'b1;

    tw_d = tw_q;
    if (s.tw_we) tw_d[s.tw_addr] = s.tw_data;

    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_dr_d    = s1_dr_q;
    s1_di_d    = s1_di_q;
    s1_w_d     = s1_w_q;
    s1_last_d  = s1_last_q;
    if (en) s1_valid_d = s.in_valid;
    if (xfer_in) begin
      s1_sum_d  = {s.in_a[2*DATA_W-1:DATA_W] + s.in_b[2*DATA_W-1:DATA_W],
                   s.in_a[DATA_W-1:0] + s.in_b[DATA_W-1:0]};
      s1_dr_d   = {s.in_a[2*DATA_W-1], s.in_a[2*DATA_W-1:DATA_W]}
                - {s.in_b[2*DATA_W-1], s.in_b[2*DATA_W-1:DATA_W]};
      s1_di_d   = {s.in_a[DATA_W-1], s.in_a[DATA_W-1:0]}
                - {s.in_b[DATA_W-1], s.in_b[DATA_W-1:0]};
      s1_w_d    = tw_q[k];
      s1_last_d = (cur == LAST_IDX);
    end
  end

  always_comb begin
    dr_x = {{(PROD_W-DATA_W-1){s1_dr_q[DATA_W]}}, s1_dr_q};
    di_x = {{(PROD_W-DATA_W-1){s1_di_q[DATA_W]}}, s1_di_q};
    wr_x = {{(PROD_W-DATA_W){s1_w_q[2*DATA_W-1]}}, s1_w_q[2*DATA_W-1:DATA_W]};
    wi_x = {{(PROD_W-DATA_W){s1_w_q[DATA_W-1]}}, s1_w_q[DATA_W-1:0]};
    p_re = dr_x * wr_x - di_x * wi_x + RND;
    p_im = dr_x * wi_x + di_x * wr_x + RND;

    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_last_d  = out_last_q;
    if (en) begin
      out_valid_d = s1_valid_q;
      out_last_d  = s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        out_a_d = s1_sum_q;
        out_b_d = {DATA_W'(p_re >>> FRAC_W), DATA_W'(p_im >>> FRAC_W)};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q      <= '0;
      for (int i = 0; i < NP; i++) tw_q[i] <= UNITY;
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      s1_dr_q     <= '0;
      s1_di_q     <= '0;
      s1_w_q      <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_last_q  <= 1'b0;
    end else begin
      pcnt_q      <= pcnt_d;
      tw_q        <= tw_d;
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      s1_dr_q     <= s1_dr_d;
      s1_di_q     <= s1_di_d;
      s1_w_q      <= s1_w_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_last_q  <= out_last_d;
    end
  end
endmodule

// File: tb/tb_fft_stage_pipe.sv
// tb/tb_fft_stage_pipe.sv - directed-vector bench for fft_stage_pipe
module tb_fft_stage_pipe;
  localparam int DW = 32;
  localparam logic [63:0] UNITY = {32'h00010000, 32'h00000000};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fft_stage_pipe_if #(.DATA_W(DW), .N(16)) if0 ();
  fft_stage_pipe_if #(.DATA_W(DW), .N(16)) if3 ();

  fft_stage_pipe #(.DATA_W(DW), .FRAC_W(16), .N(16), .STAGE(0)) u_dut_s0 (
    .clk(clk), .rst_n(rst_n), .s(if0.slave)
  );
  fft_stage_pipe #(.DATA_W(DW), .FRAC_W(16), .N(16), .STAGE(3)) u_dut_s3 (
    .clk(clk), .rst_n(rst_n), .s(if3.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        last;
  } rec_t;
  rec_t mon_q[$];

  always @(negedge clk)
    if (if0.out_valid && if0.out_ready)
      mon_q.push_back({if0.out_a, if0.out_b, if0.out_last});

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [63:0] a, input logic [63:0] b, input logic first);
    int t = 0;
    if0.in_valid = 1'b1;
    if0.in_first = first;
    if0.in_a     = a;
    if0.in_b     = b;
    @(negedge clk);
    while (!if0.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("push_timeout", 64'(t), 64'(0));
    @(posedge clk);
    #1;
    if0.in_valid = 1'b0;
    if0.in_first = 1'b0;
  endtask

  task automatic tw_write(input logic [2:0] addr, input logic [63:0] data);
    if0.tw_we   = 1'b1;
    if0.tw_addr = addr;
    if0.tw_data = data;
    @(posedge clk);
    #1;
    if0.tw_we = 1'b0;
  endtask

  task automatic wait_q(input int n, input string tag);
    int t = 0;
    while (mon_q.size() < n && t < 100) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(tag, 64'(mon_q.size()), 64'(n));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ov"}, 64'(if0.out_valid), 64'(0));
    check({tag, "_oa"}, if0.out_a, 64'(0));
    check({tag, "_ob"}, if0.out_b, 64'(0));
    check({tag, "_ol"}, 64'(if0.out_last), 64'(0));
    check({tag, "_ir"}, 64'(if0.in_ready), 64'(1));
  endtask

  logic [63:0] ea [32];
  logic [63:0] eb [32];
  logic [63:0] va [32];
  logic [63:0] vb [32];
  logic [31:0] rnd_pos, rnd_neg;

  initial begin
    if0.in_valid = 0; if0.in_first = 0; if0.in_a = 0; if0.in_b = 0;
    if0.out_ready = 1; if0.tw_we = 0; if0.tw_addr = 0; if0.tw_data = 0;
    if3.in_valid = 0; if3.in_first = 0; if3.in_a = 0; if3.in_b = 0;
    if3.out_ready = 1; if3.tw_we = 0; if3.tw_addr = 0; if3.tw_data = 0;

    #2 rst_n = 1'b0;
    #1 check_reset("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Unity twiddles on the final stage.
    if3.in_valid = 1; if3.in_first = 1;
    if3.in_a = {32'h00030000, 32'h00010000};
    if3.in_b = {32'h00010000, 32'h00020000};
    @(posedge clk); #1;
    if3.in_valid = 0; if3.in_first = 0;
    check("s3_lat1_ov", 64'(if3.out_valid), 64'(0));
    @(posedge clk); #1;
    check("s3_ov", 64'(if3.out_valid), 64'(1));
    check("s3_oa", if3.out_a, {32'h00040000, 32'h00030000});
    check("s3_ob", if3.out_b, {32'h00020000, 32'hFFFF0000});

    // Twiddle index on stage 0: only pair 4 sees -j.
    tw_write(3'd4, {32'h00000000, 32'hFFFF0000});
    mon_q.delete();
    for (int i = 0; i < 8; i++) push({32'h00010000, 32'h0}, 64'h0, i == 0);
    wait_q(8, "tw_count");
    for (int i = 0; i < 8; i++) begin
      if (i < mon_q.size()) begin
        check($sformatf("tw_a%0d", i), mon_q[i].a, {32'h00010000, 32'h0});
        check($sformatf("tw_b%0d", i), mon_q[i].b,
              (i == 4) ? {32'h0, 32'hFFFF0000} : {32'h00010000, 32'h0});
        check($sformatf("tw_last%0d", i), 64'(mon_q[i].last), 64'(i == 7));
      end
    end
    tw_write(3'd4, UNITY);

    // Backpressure: 32 pairs with a 5-cycle output stall.
    for (int i = 0; i < 32; i++) begin
      va[i] = {$urandom(), $urandom()};
      vb[i] = {$urandom(), $urandom()};
      ea[i] = {va[i][63:32] + vb[i][63:32], va[i][31:0] + vb[i][31:0]};
      eb[i] = {va[i][63:32] - vb[i][63:32], va[i][31:0] - vb[i][31:0]};
    end
    mon_q.delete();
    fork
      begin
        for (int i = 0; i < 32; i++) push(va[i], vb[i], i == 0);
      end
      begin
        logic [63:0] ha, hb;
        repeat (10) @(posedge clk);
        #1;
        if0.out_ready = 1'b0;
        ha = if0.out_a;
        hb = if0.out_b;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check($sformatf("stall_ir%0d", c), 64'(if0.in_ready), 64'(0));
          check($sformatf("stall_ov%0d", c), 64'(if0.out_valid), 64'(1));
          check($sformatf("stall_oa%0d", c), if0.out_a, ha);
          check($sformatf("stall_ob%0d", c), if0.out_b, hb);
        end
        @(posedge clk);
        #1;
        if0.out_ready = 1'b1;
      end
    join
    wait_q(32, "bp_count");
    for (int i = 0; i < 32; i++) begin
      if (i < mon_q.size()) begin
        check($sformatf("bp_a%0d", i), mon_q[i].a, ea[i]);
        check($sformatf("bp_b%0d", i), mon_q[i].b, eb[i]);
        check($sformatf("bp_last%0d", i), 64'(mon_q[i].last), 64'(i % 8 == 7));
      end
    end

    // Rounding with W = 0.5 and diff real = +1 / -1.
`ifdef FFT_ROUND_EN
    rnd_pos = 32'h00000001;
    rnd_neg = 32'h00000000;
`else
    rnd_pos = 32'h00000000;
    rnd_neg = 32'hFFFFFFFF;
`endif
    tw_write(3'd0, {32'h00008000, 32'h0});
    mon_q.delete();
    push({32'h00000001, 32'h0}, 64'h0, 1'b1);
    push({32'hFFFFFFFF, 32'h0}, 64'h0, 1'b1);
    wait_q(2, "rnd_count");
    if (mon_q.size() >= 2) begin
      check("rnd_pos", mon_q[0].b, {rnd_pos, 32'h0});
      check("rnd_neg", mon_q[1].b, {rnd_neg, 32'h0});
    end

    // Resync: in_first on the third pair restarts the frame.
    mon_q.delete();
    for (int i = 0; i < 11; i++) push(64'h0, 64'h0, (i == 0) || (i == 2));
    wait_q(11, "sync_count");
    for (int i = 0; i < 11; i++)
      if (i < mon_q.size())
        check($sformatf("sync_last%0d", i), 64'(mon_q[i].last), 64'(i == 9));

    // Reset with two pairs held in the pipe.
    if0.out_ready = 1'b0;
    push({32'h11110000, 32'h22220000}, 64'h0, 1'b1);
    push({32'h33330000, 32'h44440000}, 64'h0, 1'b0);
    rst_n = 1'b0;
    #1 check_reset("midrst");
    mon_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    if0.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("rst_flush", 64'(mon_q.size()), 64'(0));

    // Table back to unity, and counting restarts at pair 0 without in_first.
    for (int i = 0; i < 8; i++) push({32'h00010000, 32'h00020000}, 64'h0, 1'b0);
    wait_q(8, "post_count");
    for (int i = 0; i < 8; i++) begin
      if (i < mon_q.size()) begin
        check($sformatf("post_b%0d", i), mon_q[i].b, {32'h00010000, 32'h00020000});
        check($sformatf("post_last%0d", i), 64'(mon_q[i].last), 64'(i == 7));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/fft_stage_pipe.md
# fft_stage_pipe

Pipelined, parameterised radix-2 decimation-in-frequency (DIF) butterfly stage with a valid/ready stream interface and a writable twiddle table. It supersedes the fixed 16-point, unity-twiddle combinational layer. Any stage of an N-point FFT can be built from it, and stages chain directly through the handshake. Each accepted input pair (a, b) produces out_a = a + b and out_b = (a − b)·W^k.

## Interface
- DATA_W, 32: width of each real/imag component, signed two's complement.
- FRAC_W, 16: fractional bits; twiddle 1.0 = 1<<FRAC_W.
- N, 16: FFT points, power of two, ≥ 4.
- STAGE, 3: stage index, 0..log2(N)−1; STAGE = log2(N)−1 is the final stage.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input pair valid.
- in_ready  out  1  stage can accept a pair.
- in_first  in  1  accepted pair is pair 0 of a frame (counter resync).
- in_a, in_b  in  2*DATA_W  samples packed {real, imag}.
- out_valid  out  1  output pair valid.
- out_ready  in  1  downstream accepts.
- out_a, out_b  out  2*DATA_W  results packed {real, imag}.
- out_last  out  1  output pair is pair N/2−1 of its frame.
- tw_we  in  1  twiddle write strobe.
- tw_addr  in  log2(N/2)  twiddle index.
- tw_data  in  2*DATA_W  twiddle {wr, wi}.

## Operation
- Transfers: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
- Pair counter pcnt (log2(N/2) bits):
  - Increments on each input transfer and wraps from N/2−1 to 0.
  - An input transfer with in_first=1 is treated as pcnt = 0, and the counter then advances to 1.
- Twiddle index: span = N>>(STAGE+1), and k = (pcnt mod span) << STAGE.
- Twiddle table:
  - N/2 entries, flop-based.
  - Reset loads every entry to {1<<FRAC_W, 0}, i.e. W = 1.
  - A tw_we write lands on the clock edge. A pair entering S1 on the same edge reads the old value.
- Stage S1 (registered):
  - sum = a + b and diff = a − b per component, computed at DATA_W+1 bits.
  - sum is truncated to DATA_W bits (modulo wrap).
  - diff is held at DATA_W+1 bits, together with W^k and the last flag.
- Stage S2 (registered):
  - re = dr·wr − di·wi and im = dr·wi + di·wr, full precision.
  - Each result is arithmetic-shifted right by FRAC_W (optionally rounded), then truncated to DATA_W bits.
  - out_a carries the sum from S1.
- No saturation anywhere; overflow wraps.

## Timing
- Latency: 2 cycles from input transfer to out_valid, with no stall.
- Throughput: 1 pair per cycle.
- Stall and flow control:
  - Global enable en = !out_valid | out_ready, and in_ready = en.
  - When en = 0, S1 and S2 hold, and out_* stays stable while out_valid = 1.
- Bubbles: an empty S1 propagates as out_valid = 0 and does not block input.
- Reset values (asserted immediately, asynchronous):
  - out_valid = 0, out_a = out_b = 0, out_last = 0.
  - in_ready = 1 once out_valid = 0.
  - pcnt = 0; twiddle table = unity.
- Reset mid-frame: in-flight pairs are discarded and never appear at the output. The next accepted pair is pair 0.
- Simultaneous in_first with pcnt ≠ 0: in_first wins, and the partial frame is not flagged.
- out_last reflects the pcnt of the producing input, not the output transfer count.

## Configuration
- FFT_ROUND_EN defined: adds 1<<(FRAC_W−1) to each full-precision product sum before the shift (round half up).
- FFT_ROUND_EN undefined: plain arithmetic shift (truncation toward −∞).
- sum is unaffected in both cases.

## Test plan
All scenarios use defaults (N=16, FRAC_W=16) unless stated.
- Unity twiddles, STAGE=3:
  - Stimulus: a = {0x00030000, 0x00010000}, b = {0x00010000, 0x00020000}.
  - Required: 2 cycles later, out_a = {0x00040000, 0x00030000} and out_b = {0x00020000, 0xFFFF0000}.
- Twiddle index, STAGE=0:
  - Stimulus: write tw[4] = {0, 0xFFFF0000} (−j), then stream 8 pairs with a = {0x00010000, 0}, b = 0.
  - Required: pair 4 gives out_b = {0, 0xFFFF0000}; the other pairs give out_b = {0x00010000, 0}; out_last is set on pair 7 only.
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles mid-stream.
  - Required: in_ready = 0 while stalled, out_* stays stable, and no pair is lost or duplicated over 32 pairs (scoreboard).
- Rounding:
  - Stimulus: tw[0] = {0x00008000, 0}, diff real = 1.
  - Required: out_b real = 1 with FFT_ROUND_EN, 0 without.
- Resync and reset:
  - Stimulus A: in_first on the 3rd pair of a frame.
  - Required A: out_last appears 8 pairs after the resync point.
  - Stimulus B: rst_n low with 2 pairs in flight.
  - Required B: outputs go to reset values, the in-flight pairs never emerge, and the twiddle table returns to unity.
